// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Byte-lane write enables for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] en;
        case (size)
            SZ_BYTE: en = 4'b0001 << off;
            SZ_HALF: en = 4'b0011 << {off[1], 1'b0};
            SZ_WORD: en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    // Pick the addressed lanes out of a word, right-align and extend them.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    logic [31:0] mem [WORDS];

    // Byte-lane writes; the array is never reset, the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Read register only loads on a read, so the last load result is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (re) q <= mem[addr];
    end

endmodule

// File: rtl/dmem_sized.sv
// Sized data memory: byte/half/word loads and stores, hardware clear after reset.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              req_w,
    input  logic              req_r,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              err
);

    localparam int AW    = ADDR_W - 2;
    localparam int WORDS = 2 ** AW;

    state_t        state;
    logic [AW-1:0] clr_cnt;

    logic          acc, illegal, do_wr, do_rd, clearing;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_q;

    logic [1:0]    ld_size, ld_off;
    logic          ld_uns;

    // Clear sequencer: one word zeroed per cycle, ready raised after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(WORDS - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // Request decode: acceptance, legality and the resulting write/read strobes.
    always_comb begin
        acc     = ready & cs & (req_w | req_r);
        illegal = (req_w & req_r) | (size == SZ_RSVD)
                | ((size == SZ_HALF) & addr[0])
                | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
        do_wr   = acc & ~illegal & req_w;
        do_rd   = acc & ~illegal & req_r;
    end

    // RAM port mux: the clear sequence owns the port until ready rises.
    always_comb begin
        clearing  = (state == ST_CLEAR);
        ram_we    = 4'b0000;
        ram_addr  = addr[ADDR_W-1:2];
        ram_wdata = wdata << {addr[1:0], 3'b000};
        if (clearing) begin
            ram_we    = 4'b1111;
            ram_addr  = clr_cnt;
            ram_wdata = '0;
        end else if (do_wr) begin
            ram_we    = lane_en(size, addr[1:0]);
        end
    end

    dmem_ram #(.WORDS(WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (do_rd & ~clearing),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // Pulse outputs and the load shape captured alongside the read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid  <= 1'b0;
            err     <= 1'b0;
            ld_size <= SZ_BYTE;
            ld_off  <= 2'b00;
            ld_uns  <= 1'b0;
        end else begin
            rvalid <= do_rd;
            err    <= acc & illegal;
            if (do_rd) begin
                ld_size <= size;
                ld_off  <= addr[1:0];
                ld_uns  <= uns;
            end
        end
    end

    // Extraction works on held registers, so rdata holds between loads.
    assign rdata = load_ext(ram_q, ld_size, ld_off, ld_uns);

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized with a 16-word memory.
module tb_dmem_sized;
    import dmem_pkg::*;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs = 1'b0, req_w = 1'b0, req_r = 1'b0, uns = 1'b0;
    logic [1:0]        size = 2'b00;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic              ready, rvalid, err;
    logic [31:0]       rdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];
    logic        obs_v, obs_e;
    logic [31:0] obs_d;

    dmem_sized #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .req_w(req_w), .req_r(req_r),
        .size(size), .uns(uns), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    always #5 clk = ~clk;

    // One request cycle, entered and left at a falling edge; captures the response.
    task automatic drive(input logic w, input logic r, input logic [1:0] sz, input logic u,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
        cs = 1'b1; req_w = w; req_r = r; size = sz; uns = u; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; req_w = 1'b0; req_r = 1'b0;
        obs_v = rvalid; obs_e = err; obs_d = rdata;
    endtask

    task automatic store(input logic [1:0] sz, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, sz, 1'b0, a, d);
    endtask

    task automatic load(input logic [1:0] sz, input logic u, input logic [ADDR_W-1:0] a,
                        input logic [31:0] exp);
        sb.push_back(exp);
        drive(1'b0, 1'b1, sz, u, a, 32'h0);
    endtask

    task automatic test_reset;
        int n, bad;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ready, rvalid, err, rdata} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b err=%b rdata=%h, want all 0", ready, rvalid, err, rdata);
        end
        // run 7 clear cycles with gated stores to word 0, then restart the clear
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cs = 1'b1; req_w = 1'b1; size = SZ_WORD; addr = '0; wdata = 32'hFFFF_FFFF;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midclear: ready=%b want 0", ready);
        end
        rst_n = 1'b1;
        n = 0; bad = 0;
        for (int i = 1; i <= 40; i++) begin
            cs = 1'b1; req_w = i[0]; req_r = ~i[0]; size = SZ_WORD; addr = '0; wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            if (rvalid !== 1'b0 || err !== 1'b0) bad++;
            if (ready === 1'b1) begin n = i; break; end
        end
        cs = 1'b0; req_w = 1'b0; req_r = 1'b0;
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL clear_length: ready after %0d cycles, want 16", n);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL clear_gating: %0d response pulses during clear, want 0", bad);
        end
    endtask

    task automatic test_clear_zero;
        logic [31:0] want;
        for (int i = 0; i < 16; i++) begin
            load(SZ_WORD, 1'b0, ADDR_W'(i * 4), 32'h0);
            want = sb.pop_front();
            vectors++;
            if (obs_v !== 1'b1 || obs_d !== want) begin
                miscompares++;
                $display("FAIL clear_zero[%0d]: rvalid=%b rdata=%h want %h", i, obs_v, obs_d, want);
            end
        end
    endtask

    task automatic test_word;
        logic [31:0] want;
        store(SZ_WORD, 6'h10, 32'hDEAD_BEEF);
        load(SZ_WORD, 1'b0, 6'h10, 32'hDEAD_BEEF);
        want = sb.pop_front();
        vectors++;
        if (obs_v !== 1'b1 || obs_d !== want) begin
            miscompares++;
            $display("FAIL word_rt: rvalid=%b rdata=%h want %h", obs_v, obs_d, want);
        end
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0 || rdata !== want) begin
            miscompares++;
            $display("FAIL word_pulse: rvalid=%b rdata=%h want 0 / %h held", rvalid, rdata, want);
        end
    endtask

    task automatic test_bytes;
        logic [1:0]  szs[3]  = '{SZ_WORD, SZ_BYTE, SZ_BYTE};
        logic        us[3]   = '{1'b0, 1'b0, 1'b1};
        logic [31:0] exps[3] = '{32'h0080_0000, 32'hFFFF_FF80, 32'h0000_0080};
        logic [5:0]  as[3]   = '{6'h20, 6'h22, 6'h22};
        logic [31:0] want;
        store(SZ_WORD, 6'h20, 32'h0);
        store(SZ_BYTE, 6'h22, 32'hAAAA_AA80);
        for (int i = 0; i < 3; i++) begin
            load(szs[i], us[i], as[i], exps[i]);
            want = sb.pop_front();
            vectors++;
            if (obs_v !== 1'b1 || obs_d !== want) begin
                miscompares++;
                $display("FAIL byte_lane[%0d]: rvalid=%b rdata=%h want %h", i, obs_v, obs_d, want);
            end
        end
    endtask

    task automatic test_half;
        logic [1:0]  szs[3]  = '{SZ_HALF, SZ_HALF, SZ_WORD};
        logic        us[3]   = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exps[3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
        logic [5:0]  as[3]   = '{6'h06, 6'h06, 6'h04};
        logic [31:0] want;
        store(SZ_HALF, 6'h06, 32'h5555_8001);
        for (int i = 0; i < 3; i++) begin
            load(szs[i], us[i], as[i], exps[i]);
            want = sb.pop_front();
            vectors++;
            if (obs_v !== 1'b1 || obs_d !== want) begin
                miscompares++;
                $display("FAIL half[%0d]: rvalid=%b rdata=%h want %h", i, obs_v, obs_d, want);
            end
        end
    endtask

    task automatic test_illegal;
        logic       ws[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       rs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] szs[4] = '{SZ_WORD, SZ_HALF, SZ_RSVD, SZ_WORD};
        logic [5:0] as[4]  = '{6'h05, 6'h03, 6'h04, 6'h04};
        logic [31:0] want;
        store(SZ_WORD, 6'h04, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            drive(ws[i], rs[i], szs[i], 1'b0, as[i], 32'hFFFF_FFFF);
            vectors++;
            if (obs_e !== 1'b1 || obs_v !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal[%0d]: err=%b rvalid=%b want 1/0", i, obs_e, obs_v);
            end
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse: err=%b want 0", err);
        end
        load(SZ_WORD, 1'b0, 6'h04, 32'h1234_5678);
        want = sb.pop_front();
        vectors++;
        if (obs_v !== 1'b1 || obs_d !== want) begin
            miscompares++;
            $display("FAIL illegal_nowrite: rvalid=%b rdata=%h want %h", obs_v, obs_d, want);
        end
    endtask

    task automatic test_gating;
        logic [31:0] want;
        for (int i = 0; i < 2; i++) begin
            cs = 1'b0; req_w = (i == 0); req_r = (i == 1); size = SZ_WORD;
            addr = 6'h04; wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            vectors++;
            if (rvalid !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL cs_gate[%0d]: rvalid=%b err=%b want 0/0", i, rvalid, err);
            end
        end
        req_w = 1'b0; req_r = 1'b0;
        load(SZ_WORD, 1'b0, 6'h04, 32'h1234_5678);
        want = sb.pop_front();
        vectors++;
        if (obs_v !== 1'b1 || obs_d !== want) begin
            miscompares++;
            $display("FAIL cs_nowrite: rvalid=%b rdata=%h want %h", obs_v, obs_d, want);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  szs[4]  = '{SZ_WORD, SZ_BYTE, SZ_HALF, SZ_BYTE};
        logic        us[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0]  as[4]   = '{6'h10, 6'h20, 6'h06, 6'h22};
        logic [31:0] exps[4] = '{32'hDEAD_BEEF, 32'h0, 32'h0000_1234, 32'hFFFF_FF80};
        logic [31:0] want;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exps[i]);
            cs = 1'b1; req_w = 1'b0; req_r = 1'b1; size = szs[i]; uns = us[i]; addr = as[i];
            @(negedge clk);
            want = sb.pop_front();
            vectors++;
            if (rvalid !== 1'b1 || rdata !== want) begin
                miscompares++;
                $display("FAIL b2b[%0d]: rvalid=%b rdata=%h want %h", i, rvalid, rdata, want);
            end
        end
        cs = 1'b0; req_r = 1'b0;
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_tail: rvalid=%b pending=%0d want 0/0", rvalid, sb.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_clear_zero;
        test_word;
        test_bytes;
        test_half;
        test_illegal;
        test_gating;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
